// File: rtl/ras_jr31_checker.sv
// ras_jr31_checker
// Resolution-side partner of the dispatch-side return address stack.
// Each predicted JR $31 parks its predicted return address and ROB tag
// in a small slot table at dispatch. When the execution unit resolves
// that JR $31, the slot is looked up by tag, the predicted address is
// compared with the real $31 value, and a hit, mispredict or orphan
// pulse is reported one cycle later together with the correct target.
//
// Optional feature macro: RAS_CHK_STATS_EN
//   defined   -> 16-bit saturating hit/mispredict counters are built
//   undefined -> chk_hit_cnt and chk_miss_cnt are tied to zero

module ras_jr31_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     du_jr31_alloc,
    input  logic [TAG_WIDTH-1:0]     du_jr31_alloc_tag,
    input  logic [ADDR_WIDTH-1:0]    du_jr31_alloc_pred,
    input  logic                     eu_jr31_resolve,
    input  logic [TAG_WIDTH-1:0]     eu_jr31_resolve_tag,
    input  logic [ADDR_WIDTH-1:0]    eu_jr31_actual,
    input  logic                     rob_flush,
    output logic                     chk_full,
    output logic [$clog2(DEPTH):0]   chk_count,
    output logic                     chk_hit,
    output logic                     chk_mispredict,
    output logic                     chk_orphan,
    output logic [TAG_WIDTH-1:0]     chk_tag,
    output logic [ADDR_WIDTH-1:0]    chk_correct_addr,
    output logic [15:0]              chk_hit_cnt,
    output logic [15:0]              chk_miss_cnt
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // Slot table
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      valid_d;
    logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
    logic [ADDR_WIDTH-1:0] pred_q [DEPTH];

    // Registered outputs
    logic                  full_q;
    logic                  full_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  hit_q;
    logic                  miss_q;
    logic                  orphan_q;
    logic [TAG_WIDTH-1:0]  resTag_q;
    logic [ADDR_WIDTH-1:0] resAddr_q;

    // Lookup results against the pre-cycle slot state
    logic                  freeFound;
    logic [IW-1:0]         freeIdx;
    logic                  matchFound;
    logic [IW-1:0]         matchIdx;
    logic                  allocFire;
    logic                  resolveHit;
    logic                  predMatch;

    // Lowest-index free slot for dispatch and lowest-index CAM match for resolve
    always_comb begin
        freeFound  = 1'b0;
        freeIdx    = '0;
        matchFound = 1'b0;
        matchIdx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = IW'(i);
            end
            if (valid_q[i] && (tag_q[i] == eu_jr31_resolve_tag)) begin
                matchFound = 1'b1;
                matchIdx   = IW'(i);
            end
        end
    end

    assign allocFire  = du_jr31_alloc && !full_q && freeFound;
    assign resolveHit = eu_jr31_resolve && matchFound;
    assign predMatch  = (pred_q[matchIdx] == eu_jr31_actual);

    // Next slot-valid vector plus the occupancy and full flag it implies
    always_comb begin
        valid_d = valid_q;
        if (resolveHit) begin
            valid_d[matchIdx] = 1'b0;
        end
        if (allocFire) begin
            valid_d[freeIdx] = 1'b1;
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
        full_d = &valid_d;
    end

    // Slot bookkeeping and resolution reporting; reset beats flush beats normal work
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            full_q    <= 1'b0;
            count_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            orphan_q  <= 1'b0;
            resTag_q  <= '0;
            resAddr_q <= '0;
        end else if (rob_flush) begin
            valid_q   <= '0;
            full_q    <= 1'b0;
            count_q   <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            orphan_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            full_q    <= full_d;
            count_q   <= count_d;
            hit_q     <= resolveHit && predMatch;
            miss_q    <= resolveHit && !predMatch;
            orphan_q  <= eu_jr31_resolve && !matchFound;
            if (eu_jr31_resolve) begin
                resTag_q  <= eu_jr31_resolve_tag;
                resAddr_q <= eu_jr31_actual;
            end
        end
    end

    // Slot payload is only meaningful while valid, so it needs no reset
    always_ff @(posedge clk) begin
        if (!reset && !rob_flush && allocFire) begin
            tag_q[freeIdx]  <= du_jr31_alloc_tag;
            pred_q[freeIdx] <= du_jr31_alloc_pred;
        end
    end

`ifdef RAS_CHK_STATS_EN
    logic [15:0] hitCnt_q;
    logic [15:0] missCnt_q;

    // Saturating statistics, advanced on the same edge that raises the pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else if (!rob_flush && resolveHit) begin
            if (predMatch && (hitCnt_q != 16'hFFFF)) begin
                hitCnt_q <= hitCnt_q + 16'd1;
            end
            if (!predMatch && (missCnt_q != 16'hFFFF)) begin
                missCnt_q <= missCnt_q + 16'd1;
            end
        end
    end

    assign chk_hit_cnt  = hitCnt_q;
    assign chk_miss_cnt = missCnt_q;
`else
    assign chk_hit_cnt  = 16'h0000;
    assign chk_miss_cnt = 16'h0000;
`endif

    assign chk_full         = full_q;
    assign chk_count        = count_q;
    assign chk_hit          = hit_q;
    assign chk_mispredict   = miss_q;
    assign chk_orphan       = orphan_q;
    assign chk_tag          = resTag_q;
    assign chk_correct_addr = resAddr_q;

endmodule
